// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Op-code constants, state encoding and mul/div mode selectors
//            shared by the sequential ALU.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_MULTU = 4'd8;
    localparam logic [3:0] ALU_DIVU  = 4'd9;
    localparam logic [3:0] ALU_MFHI  = 4'd10;
    localparam logic [3:0] ALU_MFLO  = 4'd11;

    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_core
// Purpose  : Shared iterative datapath: shift-add multiply and restoring
//            divide, one bit per step, over a 2*WIDTH accumulator.
// Revision : 1.0
// ============================================================================
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_mode;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH:0]     w_addSum;
    logic [WIDTH:0]     w_shiftRem;
    logic [WIDTH:0]     w_trial;

    // Multiply: {hi,lo} starts as {0,B}; divide: {rem,quo} starts as {0,A}.
    always_comb begin
        w_addSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_shiftRem = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_trial    = w_shiftRem - {1'b0, r_opnd};
        if (r_mode == MD_MUL) begin
            w_accNext = {w_addSum, r_acc[WIDTH-1:1]};
        end else if (w_trial[WIDTH]) begin
            w_accNext = {w_shiftRem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_accNext = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_opnd  <= '0;
            r_mode  <= MD_MUL;
            r_count <= '0;
        end else if (load) begin
            r_acc   <= {{WIDTH{1'b0}}, (mode == MD_DIV) ? a : b};
            r_opnd  <= (mode == MD_DIV) ? b : a;
            r_mode  <= mode;
            // WIDTH is a power of two, so WIDTH-1 is all ones
            r_count <= '1;
        end else if (step) begin
            r_acc <= w_accNext;
            if (r_count != '0) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    assign last   = (r_count == '0);
    assign nextHi = w_accNext[2*WIDTH-1:WIDTH];
    assign nextLo = w_accNext[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered EX-stage ALU with single-cycle ops and iterative
//            unsigned multiply/divide into HI/LO.
// Revision : 1.0
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           r_state, w_nextState;
    logic             w_accept, w_isMulDiv, w_step, w_last, w_ovf;
    logic [WIDTH-1:0] w_mdHi, w_mdLo, w_sum, w_diff, w_aluRes;
    logic [WIDTH-1:0] r_result, r_hi, r_lo;
    logic             r_aEqB, r_aLtB, r_ovf, r_eqPend, r_ltPend;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_isMulDiv = (op == ALU_MULTU) || (op == ALU_DIVU);
    assign w_step     = (r_state == S_MUL) || (r_state == S_DIV);

    alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_accept && w_isMulDiv),
        .mode   ((op == ALU_DIVU) ? MD_DIV : MD_MUL),
        .step   (w_step),
        .a      (a),
        .b      (b),
        .last   (w_last),
        .nextHi (w_mdHi),
        .nextLo (w_mdLo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op == ALU_MULTU)     w_nextState = S_MUL;
                    else if (op == ALU_DIVU) w_nextState = S_DIV;
                    else                     w_nextState = S_DONE;
                end
            end
            S_MUL, S_DIV: if (w_last) w_nextState = S_DONE;
            S_DONE:       w_nextState = S_IDLE;
            default:      w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_sum    = a + b;
        w_diff   = a + ~b + 1'b1;
        w_aluRes = '0;
        w_ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                w_aluRes = w_sum;
                w_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_aluRes = w_diff;
                w_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  w_aluRes = a & b;
            ALU_OR:   w_aluRes = a | b;
            ALU_XOR:  w_aluRes = a ^ b;
            ALU_NOR:  w_aluRes = ~(a | b);
            ALU_SLT:  w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: w_aluRes = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_MFHI: w_aluRes = r_hi;
            ALU_MFLO: w_aluRes = r_lo;
            default:  w_aluRes = '0;
        endcase
    end

    // Mul/div flags are parked until completion so outputs change only with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_aEqB   <= 1'b0;
            r_aLtB   <= 1'b0;
            r_ovf    <= 1'b0;
            r_eqPend <= 1'b0;
            r_ltPend <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            if (w_isMulDiv) begin
                r_eqPend <= (a == b);
                r_ltPend <= (a < b);
            end else begin
                r_result <= w_aluRes;
                r_aEqB   <= (a == b);
                r_aLtB   <= (a < b);
                r_ovf    <= w_ovf;
            end
        end else if (w_step && w_last) begin
            r_result <= w_mdLo;
            r_hi     <= w_mdHi;
            r_lo     <= w_mdLo;
            r_aEqB   <= r_eqPend;
            r_aLtB   <= r_ltPend;
            r_ovf    <= 1'b0;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign a_eq_b   = r_aEqB;
    assign a_lt_b   = r_aLtB;
    assign overflow = r_ovf;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the pipeline's combinational ALU. Keeps the ADD/SUB/AND/OR encodings and the equal and less-than flags, and adds XOR/NOR/SLT/SLTU. Adds iterative unsigned multiply and divide into HI/LO registers, read back with MFHI/MFLO. Sits in the EX stage; the hazard unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥4 and a power of two.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: request; accepted only when `busy`=0.
- `op` in 4: operation code, sampled with `start`.
- `a` in WIDTH: operand A, sampled with `start`.
- `b` in WIDTH: operand B, sampled with `start`.
- `busy` out 1: operation in flight; new `start` ignored.
- `done` out 1: one-cycle pulse; `result` and flags valid this cycle.
- `result` out WIDTH: registered result; holds until the next `done`.
- `a_eq_b` out 1: registered, A==B of the accepted operands.
- `a_lt_b` out 1: registered, unsigned A<B.
- `overflow` out 1: registered, signed overflow of ADD/SUB; 0 for other ops.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 0/1), 7 SLTU (unsigned, result 0/1).
  - 8 MULTU, 9 DIVU, 10 MFHI, 11 MFLO.
  - 12–15 reserved: `result`=0, completes like a single-cycle op.
- Arithmetic is modulo 2^WIDTH; SUB is A + ~B + 1.
- `overflow` for ADD: operand signs equal and result sign differs. For SUB: operand signs differ and result sign differs from A.
- MULTU:
  - Shift-add, one bit of B per cycle.
  - The 2·WIDTH-bit product goes to {`hi`,`lo`}.
  - `result` = low product word.
- DIVU:
  - Restoring division, one quotient bit per cycle.
  - `lo` = quotient, `hi` = remainder, `result` = quotient.
  - Divide by zero needs no special case and runs the full latency: `lo` = all ones, `hi` = A.
- MFHI and MFLO return the current `hi`/`lo`. They do not modify HI/LO.
- `a_eq_b` and `a_lt_b` are computed for every op from the accepted operands.
- State machine (encoding in the package):
  - IDLE: `start`, op not 8/9 → DONE. `start`, op 8 → MUL. `start`, op 9 → DIV.
  - MUL / DIV: iterate; counter counts WIDTH-1 down to 0; at 0 → DONE, with HI/LO written on that edge.
  - DONE: `done`=1 for one cycle → IDLE.
- `busy` = (state ≠ IDLE).
- Any `start` while `busy` is ignored. Operands are captured at acceptance; later changes to `a`/`b` have no effect.

## Timing
- Reset values (async): state IDLE, `busy`=0, `done`=0, `result`=0, `a_eq_b`=0, `a_lt_b`=0, `overflow`=0, `hi`=0, `lo`=0, counter=0.
- Single-cycle ops: `start` at edge t → `done` and valid `result` after edge t+1. `busy` is high for exactly 1 cycle.
- MULTU/DIVU: `start` at edge t → `done` after edge t+WIDTH+1 (33 cycles at WIDTH=32). `busy` is high for WIDTH+1 cycles.
- Back-to-back issue: `start` may be asserted in the cycle after `done` (state is IDLE); it is accepted. Throughput for single-cycle ops is 1 per 2 cycles.
- MFHI issued immediately after a MULTU `done` returns the new HI.
- `rst_n` low mid-operation aborts it: no `done`, HI/LO cleared. The first `start` after `rst_n` rises is accepted normally.
- `done` never coincides with `busy`=0 on an accepting cycle, so `start` and `done` are never both effective in the same cycle.

## Structure
- Package `alu_pkg`: op-code constants (`ALU_ADD` … `ALU_MFLO`) and the state typedef (`S_IDLE`, `S_MUL`, `S_DIV`, `S_DONE`).
- Counter width is `$clog2(WIDTH)`, computed locally.
- One sub-module, `alu_muldiv_core`, holds the shared iterative datapath: a 2·WIDTH accumulator, the operand shift registers and the counter. It takes `load`/`mode`/`step` inputs and produces `last`.
- `alu_seq` holds the FSM, the single-cycle logic and the output registers.

## Test plan (WIDTH=32)
- ADD 0x7FFFFFFF + 1: `done` 1 cycle later, `result`=0x80000000, `overflow`=1. SUB 5−7: `result`=0xFFFFFFFE, `a_lt_b`=1, `overflow`=0.
- SLT a=0xFFFFFFFF, b=1 → `result`=1; SLTU with the same operands → `result`=0, `a_lt_b`=0. XOR/NOR of 0xF0F0F0F0 and 0xFF00FF00 → 0x0FF00FF0 / 0x000F000F.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: `done` exactly 33 cycles after acceptance. `hi`=0xFFFFFFFE, `lo`=0x00000001. Then MFHI → `result`=0xFFFFFFFE.
- DIVU 100/7 → `lo`=14, `hi`=2. DIVU 9/0 → `lo`=0xFFFFFFFF, `hi`=9, same latency.
- Issue MULTU, then pulse `start` with ADD during `busy`: the ADD is ignored, exactly one `done`, and operand changes during `busy` do not alter the result.
- Drop `rst_n` 10 cycles into DIVU: all outputs and HI/LO are 0 immediately, and no `done` appears. ADD 2+3 after reset → `result`=5 one cycle later.
